branch_target_cache: RTL and testbench

- Fetch-side branch target cache. It is the producer of the decoder's `Cache` flag and the consumer of the decoder's `PCSrc` result.
- Each cycle it looks up the fetch PC and, on a predicted-taken hit, steers fetch to the cached target.
- It registers the prediction so the flag arrives at decode aligned with the instruction.
- It trains its entries from the decode-stage resolution (`PCSrc` plus resolved target).

---
 rtl/branch_target_cache_pkg.sv | 35 +++
 rtl/btc_entry.sv | 53 +++++
 rtl/branch_target_cache.sv | 93 +++++++++
 tb/tb_branch_target_cache.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/branch_target_cache_pkg.sv
// Shared definitions for the fetch-side branch target cache, the decoder and the PC mux.
// Holds the PCSrc encodings, counter constants and the entry/resolve record layouts.
package branch_target_cache_pkg;

  typedef enum logic [2:0] {
    PCSRC_NEXT = 3'd0,
    PCSRC_BR   = 3'd1,
    PCSRC_J    = 3'd2,
    PCSRC_JR   = 3'd3,
    PCSRC_FALL = 3'd4
  } pcsrc_e;

  localparam logic [1:0] CTR_INIT = 2'b10;
  localparam logic [1:0] CTR_MAX  = 2'b11;

  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btc_entry_t;

  typedef struct packed {
    logic        en;
    logic [2:0]  src;
    logic [29:0] tag;
    logic [31:0] target;
  } btc_req_t;

  // Branch/jump that fetch did not redirect: these install or refresh an entry.
  function automatic logic is_redirect(input logic [2:0] src);
    return (src == 3'(PCSRC_BR)) || (src == 3'(PCSRC_J));
  endfunction

endpackage

// File: rtl/btc_entry.sv
// One fully-associative branch target cache entry: state, tag comparators and training.
// req.en already excludes Flush; alloc is only raised when no entry matches the resolve PC.
module btc_entry
  import branch_target_cache_pkg::*;
(
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        flush,
  input  logic [29:0] fetch_tag,
  input  btc_req_t    req,
  input  logic        cache,
  input  logic        alloc,
  output logic        fetch_hit,
  output logic        free,
  output logic        res_hit,
  output logic [31:0] target,
  output logic [1:0]  ctr
);

  btc_entry_t e;

  assign fetch_hit = e.valid && (e.tag == fetch_tag);
  assign res_hit   = e.valid && (e.tag == req.tag);
  assign free      = !e.valid;
  assign target    = e.target;
  assign ctr       = e.ctr;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      e <= '0;
    end else if (flush) begin
      e.valid <= 1'b0;
    end else if (req.en) begin
      if (is_redirect(req.src)) begin
        if (res_hit) begin
          e.target <= req.target;
          e.ctr    <= CTR_INIT;
        end else if (alloc) begin
          e <= '{valid: 1'b1, tag: req.tag, target: req.target, ctr: CTR_INIT};
        end
      end else if (res_hit) begin
        // Only a correctly-predicted taken branch strengthens; a fall-through weakens.
        if (req.src == 3'(PCSRC_NEXT) && cache && e.ctr != CTR_MAX) begin
          e.ctr <= e.ctr + 2'd1;
        end else if (req.src == 3'(PCSRC_FALL)) begin
          e.ctr <= (e.ctr == 2'b00) ? 2'b00 : e.ctr - 2'd1;
          if (e.ctr <= 2'b01) e.valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/branch_target_cache.sv
// Fetch-side branch target cache: combinational lookup, registered Cache flag toward decode,
// and training from decode resolution with lowest-invalid / round-robin victim selection.
module branch_target_cache
  import branch_target_cache_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDXW    = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] FetchPC,
  input  logic        Stall,
  input  logic        Flush,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  output logic        Cache,
  input  logic        ResolveValid,
  input  logic [31:0] ResolvePC,
  input  logic [31:0] ResolveTarget,
  input  logic [2:0]  PCSrc
);

  btc_req_t                        req;
  logic [ENTRIES-1:0]              fetch_hit, free, res_hit, alloc;
  logic [ENTRIES-1:0][31:0]        tgt;
  logic [ENTRIES-1:0][1:0]         ctr;
  logic [IDXW-1:0]                 ptr, victim;
  logic                            found, need_alloc;

  assign req = '{en: ResolveValid && !Flush, src: PCSrc,
                 tag: ResolvePC[31:2], target: ResolveTarget};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    btc_entry u_ent (
      .gclk      (Clk),
      .grst_n    (Rst_n),
      .flush     (Flush),
      .fetch_tag (FetchPC[31:2]),
      .req       (req),
      .cache     (Cache),
      .alloc     (alloc[i]),
      .fetch_hit (fetch_hit[i]),
      .free      (free[i]),
      .res_hit   (res_hit[i]),
      .target    (tgt[i]),
      .ctr       (ctr[i])
    );
  end

  assign need_alloc = req.en && is_redirect(req.src) && (res_hit == '0);

  // Lowest-index invalid entry wins; only a full table falls back to the pointer.
  always_comb begin
    victim = ptr;
    found  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (free[i] && !found) begin
        victim = IDXW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    alloc = '0;
    for (int i = 0; i < ENTRIES; i++)
      alloc[i] = need_alloc && (victim == IDXW'(i));
  end

  // Tags are unique, so the OR-reduction acts as a one-hot mux.
  always_comb begin
    PredTaken  = 1'b0;
    PredTarget = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (fetch_hit[i]) begin
        PredTaken  = PredTaken | ctr[i][1];
        PredTarget = PredTarget | tgt[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr   <= '0;
      Cache <= 1'b0;
    end else begin
      if (need_alloc && !found) ptr <= ptr + 1'b1;
      if (Flush)       Cache <= 1'b0;
      else if (!Stall) Cache <= PredTaken;
    end
  end

endmodule

// File: tb/tb_branch_target_cache.sv
// Directed bench for branch_target_cache: lookup, Cache timing, counter training,
// victim selection, flush priority and asynchronous reset, against hand-computed values.
module tb_branch_target_cache;
  import branch_target_cache_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] FetchPC;
  logic        Stall, Flush;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        Cache;
  logic        ResolveValid;
  logic [31:0] ResolvePC, ResolveTarget;
  logic [2:0]  PCSrc;

  int checks = 0;
  int errors = 0;

  branch_target_cache #(.ENTRIES(8), .IDXW(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .FetchPC(FetchPC), .Stall(Stall), .Flush(Flush),
    .PredTaken(PredTaken), .PredTarget(PredTarget), .Cache(Cache),
    .ResolveValid(ResolveValid), .ResolvePC(ResolvePC),
    .ResolveTarget(ResolveTarget), .PCSrc(PCSrc)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] tg, input logic [2:0] src);
    ResolveValid = 1'b1; ResolvePC = pc; ResolveTarget = tg; PCSrc = src;
    tick();
    ResolveValid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    FetchPC = pc;
    #1;
    chk({tag, "_taken"}, 32'(PredTaken), 32'(tk));
    chk({tag, "_tgt"}, PredTarget, tg);
  endtask

  initial begin
    Rst_n = 1'b0; FetchPC = 32'h0040_0010; Stall = 1'b0; Flush = 1'b0;
    ResolveValid = 1'b0; ResolvePC = '0; ResolveTarget = '0; PCSrc = 3'd0;
    #2;
    chk("rst_taken", 32'(PredTaken), 0);
    chk("rst_tgt", PredTarget, 0);
    chk("rst_cache", 32'(Cache), 0);
    #5 Rst_n = 1'b1;
    tick();

    // Install a branch while fetching the same PC: miss now, hit next cycle.
    FetchPC = 32'h0040_0010;
    ResolveValid = 1'b1; ResolvePC = 32'h0040_0010; ResolveTarget = 32'h0040_0100; PCSrc = 3'd1;
    #1 chk("same_cyc_miss", 32'(PredTaken), 0);
    tick();
    ResolveValid = 1'b0;
    look("first_hit", 32'h0040_0010, 1'b1, 32'h0040_0100);
    chk("cache_lag", 32'(Cache), 0);
    tick();
    chk("cache_set", 32'(Cache), 1);
    Stall = 1'b1; FetchPC = 32'h0;
    tick();
    chk("stall_hold", 32'(Cache), 1);
    Stall = 1'b0;
    tick();
    chk("cache_clr", 32'(Cache), 0);

    // Saturate to 3, then three fall-throughs: 2 (taken), 1 (not taken), invalid.
    FetchPC = 32'h0040_0010;
    tick();
    chk("cache_re", 32'(Cache), 1);
    resolve(32'h0040_0010, 32'h0, 3'd0);
    resolve(32'h0040_0010, 32'h0, 3'd0);
    resolve(32'h0040_0010, 32'h0, 3'd4);
    look("dec_to2", 32'h0040_0010, 1'b1, 32'h0040_0100);
    resolve(32'h0040_0010, 32'h0, 3'd4);
    look("dec_to1", 32'h0040_0010, 1'b0, 32'h0040_0100);
    resolve(32'h0040_0010, 32'h0, 3'd4);
    look("dec_inval", 32'h0040_0010, 1'b0, 32'h0);

    // Fill the table, then overflow through the round-robin pointer.
    Flush = 1'b1; tick(); Flush = 1'b0;
    for (int i = 0; i < 8; i++)
      resolve(32'h100 + 32'(i * 4), 32'h1000 + 32'(i * 4), 3'd2);
    look("fill_e7", 32'h11C, 1'b1, 32'h101C);
    resolve(32'h200, 32'h2000, 3'd2);
    look("evict_e0", 32'h100, 1'b0, 32'h0);
    look("new_200", 32'h200, 1'b1, 32'h2000);
    resolve(32'h204, 32'h2004, 3'd2);
    look("evict_e1", 32'h104, 1'b0, 32'h0);
    look("keep_e2", 32'h108, 1'b1, 32'h1008);
    resolve(32'h114, 32'h0, 3'd4);
    resolve(32'h114, 32'h0, 3'd4);
    look("e5_inval", 32'h114, 1'b0, 32'h0);
    resolve(32'h300, 32'h3000, 3'd1);
    look("into_e5", 32'h300, 1'b1, 32'h3000);
    resolve(32'h304, 32'h3004, 3'd1);
    look("evict_e2", 32'h108, 1'b0, 32'h0);
    look("keep_e3", 32'h10C, 1'b1, 32'h100C);

    // JR and an unconfirmed PCSrc=0 leave the entry alone.
    resolve(32'h10C, 32'hDEAD_BEE0, 3'd3);
    look("jr_nochg", 32'h10C, 1'b1, 32'h100C);
    FetchPC = 32'h0;
    tick();
    chk("cache_zero", 32'(Cache), 0);
    resolve(32'h10C, 32'h0, 3'd0);
    resolve(32'h10C, 32'h0, 3'd4);
    look("no_inc", 32'h10C, 1'b0, 32'h100C);

    // Flush beats a simultaneous resolve.
    FetchPC = 32'h200;
    tick();
    chk("pre_flush_c", 32'(Cache), 1);
    Flush = 1'b1;
    resolve(32'h400, 32'h4000, 3'd1);
    Flush = 1'b0;
    chk("flush_cache", 32'(Cache), 0);
    look("flush_drop", 32'h400, 1'b0, 32'h0);
    look("flush_e3", 32'h10C, 1'b0, 32'h0);

    // Asynchronous reset between edges.
    resolve(32'h500, 32'h5000, 3'd1);
    FetchPC = 32'h500;
    tick();
    chk("pre_rst_c", 32'(Cache), 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_taken", 32'(PredTaken), 0);
    chk("arst_tgt", PredTarget, 0);
    chk("arst_cache", 32'(Cache), 0);
    #3 Rst_n = 1'b1;
    tick();
    look("post_rst", 32'h500, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
